// File: rtl/core_inst_queue.sv
// core_inst_queue: decode->issue instruction queue. Compacts sparse write lanes in order and issues a variable count per cycle.
// Optional same-cycle bypass through an empty queue: define CORE_INST_QUEUE_BYPASS_EN.
`timescale 1ns/1ps

module core_inst_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int WRITE_PORT = 2,
    parameter int READ_PORT  = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush_i,
    input  logic [WRITE_PORT-1:0]               write_valid_i,
    input  logic [WRITE_PORT*DATA_WIDTH-1:0]    write_data_i,
    output logic                                write_ready_o,
    output logic [READ_PORT-1:0]                read_valid_o,
    output logic [READ_PORT*DATA_WIDTH-1:0]     read_data_o,
    input  logic [$clog2(READ_PORT+1)-1:0]      read_num_i,
    output logic [$clog2(DEPTH+1)-1:0]          count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef CORE_INST_QUEUE_BYPASS_EN
    localparam int COMP_N = (WRITE_PORT > READ_PORT) ? WRITE_PORT : READ_PORT;
`else
    localparam int COMP_N = WRITE_PORT;
`endif

    generate
        if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < WRITE_PORT + READ_PORT) begin : g_bad_depth
            $error("core_inst_queue: DEPTH must be a power of 2 and >= WRITE_PORT + READ_PORT");
        end
        if (WRITE_PORT < 1 || WRITE_PORT > 4 || READ_PORT < 1 || READ_PORT > 4) begin : g_bad_ports
            $error("core_inst_queue: WRITE_PORT and READ_PORT must be in 1..4");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [PTR_W-1:0]      head, tail, head_next, tail_next;
    logic [CNT_W-1:0]      count, count_next;
    logic [CNT_W-1:0]      push_cnt, pop_cnt, avail;
    logic [DATA_WIDTH-1:0] comp_data [COMP_N];
    logic [WRITE_PORT-1:0] wr_en;
    logic [PTR_W-1:0]      wr_addr [WRITE_PORT];
    logic                  accept;
`ifdef CORE_INST_QUEUE_BYPASS_EN
    logic                  bypass;
`endif

    // Ready is judged from registered occupancy only; a same-cycle pop does not earn credit.
    assign write_ready_o = (count <= CNT_W'(DEPTH - WRITE_PORT));
    assign accept        = write_ready_o && !flush_i;
    assign count_o       = count;

    // NOTE: push_cnt is a running sum updated with blocking assignments, so each lane sees the count of lower lanes.
    always_comb begin
        push_cnt = '0;
        for (int j = 0; j < COMP_N; j++) begin
            comp_data[j] = '0;
        end
        for (int k = 0; k < WRITE_PORT; k++) begin
            if (accept && write_valid_i[k]) begin
                for (int j = 0; j < WRITE_PORT; j++) begin
                    if (CNT_W'(j) == push_cnt) begin
                        comp_data[j] = write_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                push_cnt = push_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        avail = count;
`ifdef CORE_INST_QUEUE_BYPASS_EN
        bypass = (count == '0) && !flush_i;
        if (bypass) begin
            avail = push_cnt;
        end
`endif
        pop_cnt = CNT_W'(read_num_i);
        if (pop_cnt > avail) begin
            pop_cnt = avail;
        end
        if (pop_cnt > CNT_W'(READ_PORT)) begin
            pop_cnt = CNT_W'(READ_PORT);
        end
        if (flush_i) begin
            pop_cnt = '0;
        end
    end

    always_comb begin
        for (int j = 0; j < WRITE_PORT; j++) begin
            wr_en[j]   = (CNT_W'(j) < push_cnt);
            wr_addr[j] = tail + PTR_W'(j);
`ifdef CORE_INST_QUEUE_BYPASS_EN
            // Entries issued straight from the write lanes never land in the RAM.
            if (bypass) begin
                wr_en[j]   = (CNT_W'(j) < push_cnt) && (CNT_W'(j) >= pop_cnt);
                wr_addr[j] = tail + PTR_W'(j) - PTR_W'(pop_cnt);
            end
`endif
        end
    end

    always_comb begin
        head_next  = head + PTR_W'(pop_cnt);
        tail_next  = tail + PTR_W'(push_cnt);
        count_next = count + push_cnt - pop_cnt;
`ifdef CORE_INST_QUEUE_BYPASS_EN
        if (bypass) begin
            head_next = head;
            tail_next = tail + PTR_W'(push_cnt - pop_cnt);
        end
`endif
        if (flush_i) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
        end
    end

    // NOTE: the entry RAM is deliberately not reset; read_valid_o masks stale contents.
    always_ff @(posedge clk) begin
        for (int j = 0; j < WRITE_PORT; j++) begin
            if (wr_en[j]) begin
                ram[wr_addr[j]] <= comp_data[j];
            end
        end
    end

    always_comb begin
        read_data_o  = '0;
        read_valid_o = '0;
        for (int i = 0; i < READ_PORT; i++) begin
            read_data_o[i*DATA_WIDTH +: DATA_WIDTH] = ram[head + PTR_W'(i)];
            read_valid_o[i]                         = (count > CNT_W'(i));
`ifdef CORE_INST_QUEUE_BYPASS_EN
            if (bypass) begin
                read_data_o[i*DATA_WIDTH +: DATA_WIDTH] = comp_data[i];
                read_valid_o[i]                         = (push_cnt > CNT_W'(i));
            end
`endif
        end
    end

endmodule

// File: tb/tb_core_inst_queue.sv
// tb_core_inst_queue: randomized scoreboard bench for core_inst_queue against a queue-based reference model.
`timescale 1ns/1ps

module tb_core_inst_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int WP    = 2;
    localparam int RP    = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NUM_W = $clog2(RP + 1);
`ifdef CORE_INST_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic             ready;
        logic [RP-1:0]    valid;
        logic [RP*DW-1:0] data;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               flush_i;
    logic [WP-1:0]      write_valid_i;
    logic [WP*DW-1:0]   write_data_i;
    logic               write_ready_o;
    logic [RP-1:0]      read_valid_o;
    logic [RP*DW-1:0]   read_data_o;
    logic [NUM_W-1:0]   read_num_i;
    logic [CNT_W-1:0]   count_o;

    int                 n_checks = 0;
    int                 n_errors = 0;
    exp_t               exp_q[$];
    logic [DW-1:0]      mq[$];
    exp_t               mon_e;
    logic [DW-1:0]      tag = 32'h1000_0000;

    core_inst_queue #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .WRITE_PORT (WP),
        .READ_PORT  (RP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .write_valid_i (write_valid_i),
        .write_data_i  (write_data_i),
        .write_ready_o (write_ready_o),
        .read_valid_o  (read_valid_o),
        .read_data_o   (read_data_o),
        .read_num_i    (read_num_i),
        .count_o       (count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the expected outputs for this cycle go to the scoreboard, then the model advances.
    task automatic drive(input logic [WP-1:0] wv, input logic [WP*DW-1:0] wd, input int rn, input logic fl);
        exp_t          e;
        logic [DW-1:0] w[$];
        logic [DW-1:0] vis[$];
        int            pop;
        bit            ready;
        bit            byp;
        @(negedge clk);
        write_valid_i = wv;
        write_data_i  = wd;
        read_num_i    = NUM_W'(rn);
        flush_i       = fl;
        ready = (DEPTH - mq.size()) >= WP;
        if (ready && !fl) begin
            for (int k = 0; k < WP; k++) begin
                if (wv[k]) w.push_back(wd[k*DW +: DW]);
            end
        end
        byp = BYPASS && (mq.size() == 0) && !fl;
        if (byp) vis = w;
        else     vis = mq;
        e.count = CNT_W'(mq.size());
        e.ready = ready;
        e.valid = '0;
        e.data  = '0;
        for (int i = 0; i < RP; i++) begin
            if (i < vis.size()) begin
                e.valid[i]       = 1'b1;
                e.data[i*DW +: DW] = vis[i];
            end
        end
        exp_q.push_back(e);
        pop = rn;
        if (pop > vis.size()) pop = vis.size();
        if (pop > RP) pop = RP;
        if (fl) begin
            mq.delete();
        end else if (byp) begin
            for (int j = pop; j < w.size(); j++) mq.push_back(w[j]);
        end else begin
            repeat (pop) void'(mq.pop_front());
            foreach (w[j]) mq.push_back(w[j]);
        end
    endtask

    task automatic push2(input int rn);
        logic [WP*DW-1:0] d;
        d = {tag + 32'd1, tag};
        tag = tag + 32'd2;
        drive(2'b11, d, rn, 1'b0);
    endtask

    task automatic idle(input int rn);
        drive('0, '0, rn, 1'b0);
    endtask

    // Checks the outputs of the cycle whose inputs were just driven.
    task automatic expect_state(input string name, input int cnt, input logic rdy, input logic [RP-1:0] vld);
        #2;
        check({name, "_count"}, 64'(count_o), 64'(cnt));
        check({name, "_ready"}, 64'(write_ready_o), 64'(rdy));
        check({name, "_valid"}, 64'(read_valid_o), 64'(vld));
    endtask

    task automatic do_reset();
        @(negedge clk);
        write_valid_i = '0;
        read_num_i    = '0;
        flush_i       = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_count", 64'(count_o), 64'(0));
        check("arst_valid", 64'(read_valid_o), 64'(0));
        check("arst_ready", 64'(write_ready_o), 64'(1));
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("count_o", 64'(count_o), 64'(mon_e.count));
                check("write_ready_o", 64'(write_ready_o), 64'(mon_e.ready));
                check("read_valid_o", 64'(read_valid_o), 64'(mon_e.valid));
                for (int i = 0; i < RP; i++) begin
                    if (mon_e.valid[i]) begin
                        check($sformatf("lane%0d_data", i), 64'(read_data_o[i*DW +: DW]),
                              64'(mon_e.data[i*DW +: DW]));
                    end
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        flush_i       = 1'b0;
        write_valid_i = '0;
        write_data_i  = '0;
        read_num_i    = '0;
        #3;
        check("reset_count", 64'(count_o), 64'(0));
        check("reset_valid", 64'(read_valid_o), 64'(0));
        check("reset_ready", 64'(write_ready_o), 64'(1));
        @(negedge clk);
        rst = 1'b0;

        // Sparse lane mask: only lane 1 carries an instruction.
        drive(2'b10, {32'hB0B0_0001, 32'hDEAD_0000}, 0, 1'b0);
        idle(0);
        expect_state("sparse", 1, 1'b1, 2'b01);
        check("sparse_lane0", 64'(read_data_o[DW-1:0]), 64'(32'hB0B0_0001));
        // Pop request above occupancy is clamped.
        idle(2);
        idle(0);
        expect_state("clamp", 0, 1'b1, 2'b00);

        // Asynchronous reset with five entries held.
        push2(0);
        push2(0);
        drive(2'b01, {32'h0, tag}, 0, 1'b0);
        tag = tag + 32'd1;
        idle(0);
        expect_state("pre_rst", 5, 1'b1, 2'b11);
        do_reset();

        // Fill to full, attempt an ignored write, then drain one at a time.
        repeat (4) push2(0);
        push2(0);
        expect_state("full", 8, 1'b0, 2'b11);
        idle(1);
        expect_state("full_ignored", 8, 1'b0, 2'b11);
        idle(1);
        expect_state("pop_to_7", 7, 1'b0, 2'b11);
        idle(0);
        expect_state("pop_to_6", 6, 1'b1, 2'b11);

        // Head wraps at 7 with simultaneous push and pop.
        do_reset();
        repeat (4) push2(0);
        repeat (3) idle(2);
        idle(1);
        push2(0);
        push2(2);
        idle(0);
        expect_state("wrap", 3, 1'b1, 2'b11);

        // Flush wins over same-cycle push and pop; outputs still pre-flush in that cycle.
        do_reset();
        repeat (3) push2(0);
        drive(2'b11, {32'hF1F1_F1F1, 32'hF0F0_F0F0}, 2, 1'b1);
        expect_state("flush_cycle", 6, 1'b1, 2'b11);
        idle(0);
        expect_state("after_flush", 0, 1'b1, 2'b00);

        for (int c = 0; c < 3000; c++) begin
            int rn_max;
            rn_max = ((c / 400) % 2 == 0) ? 3 : 1;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                drive(WP'($urandom), {$urandom, $urandom}, int'($urandom_range(0, rn_max)),
                      ($urandom_range(0, 24) == 0));
            end
        end

        repeat (2) idle(0);
        @(negedge clk);
        #2;
        check("sb_drain", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
